ia_fetch_controller: RTL and testbench

Sequencer for the input-activation fetch path: drives the IA BRAM read port (`enable`, `address`) and the lane arbiter `control` so four consecutive BRAM rows load into arbiter lanes op_1..op_4, forming one IA tile. It then presents the assembled tile to the convolution datapath with a valid/ready handshake and repeats for a programmed number of tiles. Sits between the layer scheduler (start/done) and the IA storage/arbiter module.

---
 rtl/ia_ctrl_pkg.sv | 33 +++
 rtl/ia_addr_gen.sv | 67 ++++++
 rtl/ia_fetch_controller.sv | 179 +++++++++++++++++
 tb/tb_ia_fetch_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ia_ctrl_pkg.sv
// Shared definitions for the IA fetch path: FSM state encoding, arbiter
// command codes and lane geometry.
package ia_ctrl_pkg;

  // Number of arbiter lanes (op_1..op_4) that make up one IA tile.
  localparam int LANE_COUNT = 4;
  localparam int LANE_W     = $clog2(LANE_COUNT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_WAIT    = 3'd2,
    S_LOAD    = 3'd3,
    S_PRESENT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Lane arbiter commands; codes 6 and 7 are never driven.
  typedef enum logic [2:0] {
    ARB_HOLD  = 3'd0,
    ARB_LOAD1 = 3'd1,
    ARB_LOAD2 = 3'd2,
    ARB_LOAD3 = 3'd3,
    ARB_LOAD4 = 3'd4,
    ARB_CLEAR = 3'd5
  } arb_cmd_t;

  // LOAD command for a zero-based lane index (lane 0 -> LOAD1).
  function automatic logic [2:0] arb_load(input logic [LANE_W-1:0] lane);
    return 3'(lane) + 3'd1;
  endfunction

endpackage

// File: rtl/ia_addr_gen.sv
// Address generator for the IA fetch path. Holds the base/tile/lane
// registers and produces the registered BRAM row address
// base + 4*tile + lane, wrapping at 2^address_width.
module ia_addr_gen
  import ia_ctrl_pkg::*;
#(
  parameter int address_width  = 5,
  parameter int tile_cnt_width = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load,       // start of run: latch base, zero tile/lane
  input  logic [address_width-1:0]  base_addr,
  input  logic                      lane_inc,
  input  logic                      lane_clr,
  input  logic                      tile_inc,
  input  logic                      rd_next,    // next cycle is a READ
  output logic [LANE_W-1:0]         lane,
  output logic [tile_cnt_width-1:0] tile,
  output logic [address_width-1:0]  bram_addr
);

  logic [address_width-1:0]  base_q, base_n;
  logic [tile_cnt_width-1:0] tile_q, tile_n;
  logic [LANE_W-1:0]         lane_q, lane_n;
  logic [address_width-1:0]  addr_n;

  // Next-cycle base/tile/lane and the address they select, so the address
  // register lines up with the READ state rather than trailing it.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    base_n = base_q;
    tile_n = tile_q;
    lane_n = lane_q;
    if (load) begin
      base_n = base_addr;
      tile_n = '0;
      lane_n = '0;
    end else begin
      if (lane_inc) lane_n = lane_q + 1'b1;
      if (lane_clr) lane_n = '0;
      if (tile_inc) tile_n = tile_q + 1'b1;
    end
    // Truncation to address_width gives the silent wrap.
    addr_n = base_n + (address_width'(tile_n) << 2) + address_width'(lane_n);
  end

  // Row registers and registered address; address reads as 0 outside READ.
  always_ff @(posedge clock) begin
    if (reset) begin
      base_q    <= '0;
      tile_q    <= '0;
      lane_q    <= '0;
      bram_addr <= '0;
    end else begin
      base_q    <= base_n;
      tile_q    <= tile_n;
      lane_q    <= lane_n;
      bram_addr <= rd_next ? addr_n : '0;
    end
  end

  assign lane = lane_q;
  assign tile = tile_q;

endmodule

// File: rtl/ia_fetch_controller.sv
// IA fetch sequencer: reads four consecutive BRAM rows into arbiter lanes
// op_1..op_4, presents the tile with valid/ready, repeats tile_count times.
// All outputs are registered from the next-state decode, so they change on
// the edge that enters a state and never follow inputs combinationally.
// Optional build macro IA_FETCH_PERF_EN adds the stall_cycles counter port.
module ia_fetch_controller
  import ia_ctrl_pkg::*;
#(
  parameter int address_width  = 5,
  parameter int bram_latency   = 1,   // legal 1..3
  parameter int tile_cnt_width = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [address_width-1:0]  base_addr,
  input  logic [tile_cnt_width-1:0] tile_count,
  input  logic                      abort,
  output logic                      bram_en,
  output logic [address_width-1:0]  bram_addr,
  output logic [2:0]                arb_control,
  output logic                      tile_valid,
  input  logic                      tile_ready,
  output logic                      busy,
  output logic                      done
`ifdef IA_FETCH_PERF_EN
  ,
  output logic [31:0]               stall_cycles
`endif
);

  state_t                    state_q, state_n;
  logic [1:0]                wait_q, wait_n;
  logic [tile_cnt_width-1:0] tile_cnt_q;
  logic [tile_cnt_width-1:0] tile_q, tile_next;
  logic [LANE_W-1:0]         lane_q;
  logic                      load, lane_inc, lane_clr, tile_inc;
  logic                      en_n, valid_n, busy_n, done_n;
  logic [2:0]                arb_n;

  assign tile_next = tile_q + 1'b1;

  // Next-state logic, address-generator commands and next output values.
  always_comb begin
    state_n  = state_q;
    wait_n   = wait_q;
    load     = 1'b0;
    lane_inc = 1'b0;
    lane_clr = 1'b0;
    tile_inc = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (tile_count == '0) begin
            state_n = S_DONE;
          end else begin
            state_n = S_READ;
            load    = 1'b1;
          end
        end
      end
      S_READ: begin
        if (bram_latency > 1) begin
          state_n = S_WAIT;
          wait_n  = '0;
        end else begin
          state_n = S_LOAD;
        end
      end
      S_WAIT: begin
        // Stay bram_latency-1 cycles so LOAD lands bram_latency after READ.
        if (int'(wait_q) >= bram_latency - 2) state_n = S_LOAD;
        else                                  wait_n  = wait_q + 1'b1;
      end
      S_LOAD: begin
        if (lane_q < LANE_W'(LANE_COUNT - 1)) begin
          lane_inc = 1'b1;
          state_n  = S_READ;
        end else begin
          lane_clr = 1'b1;
          state_n  = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (tile_ready) begin
          tile_inc = 1'b1;
          state_n  = (tile_next == tile_cnt_q) ? S_DONE : S_READ;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Abort beats everything else, including a simultaneous accept.
    if (abort && state_q != S_IDLE) begin
      state_n  = S_IDLE;
      lane_inc = 1'b0;
      lane_clr = 1'b0;
      tile_inc = 1'b0;
    end

    // Outputs decoded from the state being entered.
    en_n    = (state_n == S_READ);
    valid_n = (state_n == S_PRESENT);
    busy_n  = (state_n != S_IDLE);
    done_n  = 1'b0;
    arb_n   = ARB_HOLD;
    case (state_n)
      S_LOAD: arb_n = arb_load(lane_q);
      S_DONE: begin
        arb_n  = ARB_CLEAR;
        done_n = 1'b1;
      end
      default: arb_n = ARB_HOLD;
    endcase
    if (abort && state_q != S_IDLE) arb_n = ARB_CLEAR;
  end

  // State, latency counter, latched tile count and registered outputs.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      tile_cnt_q  <= '0;
      bram_en     <= 1'b0;
      arb_control <= ARB_HOLD;
      tile_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_n;
      wait_q      <= wait_n;
      if (load) tile_cnt_q <= tile_count;
      bram_en     <= en_n;
      arb_control <= arb_n;
      tile_valid  <= valid_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  ia_addr_gen #(
    .address_width  (address_width),
    .tile_cnt_width (tile_cnt_width)
  ) u_addr_gen (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .base_addr (base_addr),
    .lane_inc  (lane_inc),
    .lane_clr  (lane_clr),
    .tile_inc  (tile_inc),
    .rd_next   (en_n),
    .lane      (lane_q),
    .tile      (tile_q),
    .bram_addr (bram_addr)
  );

`ifdef IA_FETCH_PERF_EN
  logic [31:0] stall_q;

  // Saturating count of cycles the presented tile waits on downstream.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_q <= '0;
    end else if (tile_valid && !tile_ready && stall_q != '1) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ia_fetch_controller.sv
// Directed bench for ia_fetch_controller: one instance with bram_latency=1,
// one with bram_latency=2, sharing stimulus.
module tb_ia_fetch_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       tile_ready = 1'b1;
  logic [4:0] base_addr = '0;
  logic [3:0] tile_count = '0;

  logic       l1_en, l1_valid, l1_busy, l1_done;
  logic [4:0] l1_addr;
  logic [2:0] l1_arb;
  logic       l2_en, l2_valid, l2_busy, l2_done;
  logic [4:0] l2_addr;
  logic [2:0] l2_arb;
`ifdef IA_FETCH_PERF_EN
  logic [31:0] l1_stall, l2_stall;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ia_fetch_controller #(.address_width(5), .bram_latency(1), .tile_cnt_width(4)) u_dut_l1 (
    .clock (clock), .reset (reset), .start (start), .base_addr (base_addr),
    .tile_count (tile_count), .abort (abort), .bram_en (l1_en), .bram_addr (l1_addr),
    .arb_control (l1_arb), .tile_valid (l1_valid), .tile_ready (tile_ready),
    .busy (l1_busy), .done (l1_done)
`ifdef IA_FETCH_PERF_EN
    , .stall_cycles (l1_stall)
`endif
  );

  ia_fetch_controller #(.address_width(5), .bram_latency(2), .tile_cnt_width(4)) u_dut_l2 (
    .clock (clock), .reset (reset), .start (start), .base_addr (base_addr),
    .tile_count (tile_count), .abort (abort), .bram_en (l2_en), .bram_addr (l2_addr),
    .arb_control (l2_arb), .tile_valid (l2_valid), .tile_ready (tile_ready),
    .busy (l2_busy), .done (l2_done)
`ifdef IA_FETCH_PERF_EN
    , .stall_cycles (l2_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; observe and drive 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    tile_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Pulse start for one edge; on return the bench observes cycle 1.
  task automatic begin_run(input logic [4:0] b, input logic [3:0] n);
    base_addr  = b;
    tile_count = n;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_l1_zero(input string tag);
    check({tag, "_en"},    32'(l1_en),    0);
    check({tag, "_addr"},  32'(l1_addr),  0);
    check({tag, "_arb"},   32'(l1_arb),   0);
    check({tag, "_valid"}, 32'(l1_valid), 0);
    check({tag, "_busy"},  32'(l1_busy),  0);
    check({tag, "_done"},  32'(l1_done),  0);
`ifdef IA_FETCH_PERF_EN
    check({tag, "_stall"}, l1_stall, 0);
`endif
  endtask

  task automatic check_l2_zero(input string tag);
    check({tag, "_en"},    32'(l2_en),    0);
    check({tag, "_addr"},  32'(l2_addr),  0);
    check({tag, "_arb"},   32'(l2_arb),   0);
    check({tag, "_valid"}, 32'(l2_valid), 0);
    check({tag, "_busy"},  32'(l2_busy),  0);
    check({tag, "_done"},  32'(l2_done),  0);
`ifdef IA_FETCH_PERF_EN
    check({tag, "_stall"}, l2_stall, 0);
`endif
  endtask

  initial begin
    logic [4:0] exp_wrap [4];
    int         e_en, e_addr, e_arb, e_valid, e_done;
    int         p, t;

    exp_wrap = '{5'd30, 5'd31, 5'd0, 5'd1};

    // Reset state
    do_reset();
    check_l1_zero("rst_l1");
    check_l2_zero("rst_l2");

    // Latency 1, base 4, one tile: READ on odd cycles, LOAD on even cycles
    begin_run(5'd4, 4'd1);
    for (int c = 1; c <= 10; c++) begin
      e_en    = (c <= 8 && c % 2 == 1) ? 1 : 0;
      e_arb   = (c <= 8 && c % 2 == 0) ? c / 2 : ((c == 10) ? 5 : 0);
      e_valid = (c == 9) ? 1 : 0;
      e_done  = (c == 10) ? 1 : 0;
      check($sformatf("t1_en_c%0d", c),    32'(l1_en),    32'(e_en));
      if (e_en == 1) check($sformatf("t1_addr_c%0d", c), 32'(l1_addr), 32'(4 + (c - 1) / 2));
      check($sformatf("t1_arb_c%0d", c),   32'(l1_arb),   32'(e_arb));
      check($sformatf("t1_valid_c%0d", c), 32'(l1_valid), 32'(e_valid));
      check($sformatf("t1_done_c%0d", c),  32'(l1_done),  32'(e_done));
      check($sformatf("t1_busy_c%0d", c),  32'(l1_busy),  1);
      tick();
    end
    check("t1_busy_after", 32'(l1_busy), 0);
    check("t1_done_after", 32'(l1_done), 0);

    // Latency 2, base 0, two tiles: READ/WAIT/LOAD triples, 12 cycles per tile
    do_reset();
    begin_run(5'd0, 4'd2);
    for (int c = 1; c <= 27; c++) begin
      e_en = 0; e_addr = 0; e_arb = 0; e_valid = 0; e_done = 0;
      if (c == 13 || c == 26) begin
        e_valid = 1;
      end else if (c == 27) begin
        e_done = 1;
        e_arb  = 5;
      end else begin
        t = (c <= 12) ? 0 : 1;
        p = (c <= 12) ? c - 1 : c - 14;
        if (p % 3 == 0) begin
          e_en   = 1;
          e_addr = 4 * t + p / 3;
        end else if (p % 3 == 2) begin
          e_arb = p / 3 + 1;
        end
      end
      check($sformatf("t2_en_c%0d", c),    32'(l2_en),    32'(e_en));
      if (e_en == 1) check($sformatf("t2_addr_c%0d", c), 32'(l2_addr), 32'(e_addr));
      check($sformatf("t2_arb_c%0d", c),   32'(l2_arb),   32'(e_arb));
      check($sformatf("t2_valid_c%0d", c), 32'(l2_valid), 32'(e_valid));
      check($sformatf("t2_done_c%0d", c),  32'(l2_done),  32'(e_done));
      check($sformatf("t2_busy_c%0d", c),  32'(l2_busy),  1);
      tick();
    end
    check("t2_busy_after", 32'(l2_busy), 0);

    // Address wrap: base 30 gives rows 30, 31, 0, 1
    do_reset();
    begin_run(5'd30, 4'd1);
    for (int c = 1; c <= 8; c++) begin
      if (c % 2 == 1) begin
        check($sformatf("t3_en_c%0d", c),   32'(l1_en),   1);
        check($sformatf("t3_addr_c%0d", c), 32'(l1_addr), 32'(exp_wrap[(c - 1) / 2]));
      end
      tick();
    end

    // Back-pressure: tile_ready low for the first 5 PRESENT cycles
    do_reset();
    tile_ready = 1'b0;
    begin_run(5'd0, 4'd1);
    for (int c = 1; c < 9; c++) tick();
    for (int c = 9; c <= 14; c++) begin
      check($sformatf("t4_valid_c%0d", c), 32'(l1_valid), 1);
      check($sformatf("t4_en_c%0d", c),    32'(l1_en),    0);
      check($sformatf("t4_arb_c%0d", c),   32'(l1_arb),   0);
      check($sformatf("t4_done_c%0d", c),  32'(l1_done),  0);
      if (c == 14) tile_ready = 1'b1;
      tick();
    end
    check("t4_done_c15",  32'(l1_done),  1);
    check("t4_valid_c15", 32'(l1_valid), 0);
`ifdef IA_FETCH_PERF_EN
    check("t4_stall_c15", l1_stall, 5);
`endif

    // Abort during the second LOAD, with a simultaneous start
    do_reset();
    begin_run(5'd0, 4'd1);
    tick(); tick(); tick();
    check("t5_arb_load2", 32'(l1_arb), 2);
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    check("t5_arb_clear", 32'(l1_arb),   5);
    check("t5_busy_c5",   32'(l1_busy),  0);
    check("t5_done_c5",   32'(l1_done),  0);
    check("t5_en_c5",     32'(l1_en),    0);
    check("t5_valid_c5",  32'(l1_valid), 0);
    tick();
    check("t5_arb_c6",  32'(l1_arb),  0);
    check("t5_busy_c6", 32'(l1_busy), 0);
    check("t5_done_c6", 32'(l1_done), 0);
    check("t5_en_c6",   32'(l1_en),   0);
    tick();
    check("t5_busy_c7", 32'(l1_busy), 0);
    check("t5_done_c7", 32'(l1_done), 0);

    // Zero tiles: straight to DONE, no BRAM access
    do_reset();
    begin_run(5'd3, 4'd0);
    check("t6_done_c1",    32'(l1_done), 1);
    check("t6_busy_c1",    32'(l1_busy), 1);
    check("t6_en_c1",      32'(l1_en),   0);
    check("t6_arb_c1",     32'(l1_arb),  5);
    check("t6_l2_done_c1", 32'(l2_done), 1);
    check("t6_l2_en_c1",   32'(l2_en),   0);
    tick();
    check("t6_done_c2", 32'(l1_done), 0);
    check("t6_busy_c2", 32'(l1_busy), 0);
    check("t6_en_c2",   32'(l1_en),   0);

    // Reset while the latency-2 instance sits in WAIT
    do_reset();
    begin_run(5'd9, 4'd1);
    check("t7_l2_read_en", 32'(l2_en), 1);
    tick();
    check("t7_l2_wait_en",   32'(l2_en),   0);
    check("t7_l2_wait_busy", 32'(l2_busy), 1);
    reset = 1'b1;
    tick();
    check_l2_zero("t7_l2");
    check_l1_zero("t7_l1");
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
